// File: rtl/api_slave.sv
// -----------------------------------------------------------------------------
// api_slave
//
// Chip-side responder for the api serial link (mode 0, MSB first).
// While load is low, mosi is deserialised into 32-bit work words and,
// at the same time, response words from a first-word-fall-through FIFO are
// serialised onto miso. load, sck and mosi are asynchronous to clk and are
// oversampled through SYNC_STAGES flops each.
//
// Ports:
//   clk          system clock, at least 4x the sck frequency
//   rst          synchronous, active-high reset
//   reg_word_num words per transaction (0 means 256), captured at select
//   load         active-low chip select from the master
//   sck          serial clock, idles low
//   mosi         serial data in, MSB first
//   miso         serial data out, MSB first
//   rx_vld       one-cycle pulse, rx_dat/rx_idx/rx_last are valid
//   rx_dat       received word
//   rx_idx       0-based index of the word inside the transaction
//   rx_last      set with rx_vld on the final word of the transaction
//   rx_abort     one-cycle pulse, load rose before the transaction completed
//   resp_empty   response FIFO empty
//   resp_rd_en   one-cycle FIFO pop, resp_dout is consumed in the same cycle
//   resp_dout    response FIFO head
//   busy         high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module api_slave #(
   parameter int   SYNC_STAGES = 2,
   parameter int   RESP_LEN    = 4,
   parameter logic IDLE_MISO   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  reg_word_num,
   input  logic        load,
   input  logic        sck,
   input  logic        mosi,
   output logic        miso,
   output logic        rx_vld,
   output logic [31:0] rx_dat,
   output logic [7:0]  rx_idx,
   output logic        rx_last,
   output logic        rx_abort,
   input  logic        resp_empty,
   output logic        resp_rd_en,
   input  logic [31:0] resp_dout,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD_TX,
      SHIFT,
      HOLD
   } state_t;

   localparam logic [8:0]  RESP_LEN_W = 9'(RESP_LEN);
   localparam logic [31:0] IDLE_WORD  = {32{IDLE_MISO}};

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] load_sync;
   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   load_prev;
   logic                   sck_prev;

   logic load_s;
   logic sck_s;
   logic mosi_s;
   logic load_fall;
   logic sck_rise;
   logic sck_fall;

   logic [31:0] rx_sr;
   logic [31:0] tx_sr;
   logic [4:0]  bit_cnt;
   logic [8:0]  word_cnt;
   logic [8:0]  word_num;

   logic have_resp;
   logic last_word;
   logic start;
   logic preload;
   logic shift_in;
   logic shift_out;
   logic word_done;
   logic abort;

   assign load_s    = load_sync[SYNC_STAGES-1];
   assign sck_s     = sck_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign load_fall = load_prev & ~load_s;
   assign sck_rise  = sck_s & ~sck_prev;
   assign sck_fall  = ~sck_s & sck_prev;

   // word_cnt and word_num are 9 bits wide so that a programmed count of 0
   // can stand for a full 256-word transaction.
   assign have_resp = (word_cnt < RESP_LEN_W) && !resp_empty;
   assign last_word = ((word_cnt + 9'd1) == word_num);

   // Input synchronisers plus one extra sample of the last stage for edge
   // detection. The reset values make the link look deselected and idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         load_sync <= '1;
         sck_sync  <= '0;
         mosi_sync <= '0;
         load_prev <= 1'b1;
         sck_prev  <= 1'b0;
      end else begin
         load_sync <= {load_sync[SYNC_STAGES-2:0], load};
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         load_prev <= load_s;
         sck_prev  <= sck_s;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and one-cycle control strobes for the datapath.
   // A word that completes in the same cycle as load rising is still
   // delivered; only an incomplete transaction is then reported as aborted.
   // The final word goes to HOLD, which leaves without an abort.
   always_comb begin
      state_next = state;
      start      = 1'b0;
      preload    = 1'b0;
      resp_rd_en = 1'b0;
      shift_in   = 1'b0;
      shift_out  = 1'b0;
      word_done  = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (load_fall) begin
               start      = 1'b1;
               state_next = LOAD_TX;
            end
         end
         LOAD_TX: begin
            if (load_s) begin
               abort      = 1'b1;
               state_next = IDLE;
            end else begin
               preload    = 1'b1;
               resp_rd_en = have_resp;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (sck_rise) begin
               shift_in = 1'b1;
               if (bit_cnt == 5'd31) begin
                  word_done = 1'b1;
               end
            end
            if (sck_fall && (bit_cnt != 5'd0)) begin
               shift_out = 1'b1;
            end
            if (word_done) begin
               if (last_word) begin
                  state_next = HOLD;
               end else if (load_s) begin
                  abort      = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = LOAD_TX;
               end
            end else if (load_s) begin
               abort      = 1'b1;
               state_next = IDLE;
            end
         end
         HOLD: begin
            if (load_s) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Shift registers, counters and registered receive outputs.
   // The bit_cnt!=0 guard on the tx shift keeps the fall that follows the
   // 32nd rise from pushing out the freshly preloaded MSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_sr    <= '0;
         tx_sr    <= IDLE_WORD;
         bit_cnt  <= '0;
         word_cnt <= '0;
         word_num <= '0;
         rx_vld   <= 1'b0;
         rx_dat   <= '0;
         rx_idx   <= '0;
         rx_last  <= 1'b0;
         rx_abort <= 1'b0;
      end else begin
         rx_vld   <= word_done;
         rx_abort <= abort;
         if (start) begin
            word_num <= {(reg_word_num == 8'd0), reg_word_num};
            word_cnt <= '0;
            bit_cnt  <= '0;
         end
         if (preload) begin
            tx_sr <= have_resp ? resp_dout : IDLE_WORD;
         end
         if (shift_out) begin
            tx_sr <= {tx_sr[30:0], IDLE_MISO};
         end
         if (shift_in) begin
            rx_sr   <= {rx_sr[30:0], mosi_s};
            bit_cnt <= bit_cnt + 5'd1;
         end
         if (word_done) begin
            rx_dat   <= {rx_sr[30:0], mosi_s};
            rx_idx   <= word_cnt[7:0];
            rx_last  <= last_word;
            word_cnt <= word_cnt + 9'd1;
         end
      end
   end

   assign miso = ((state == LOAD_TX) || (state == SHIFT)) ? tx_sr[31] : IDLE_MISO;
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_api_slave.sv
// -----------------------------------------------------------------------------
// tb_api_slave
//
// Self-checking bench for api_slave. A simple master drives mode-0
// transactions and captures miso; a FIFO model supplies response words.
// Expected results come from a transaction-level model: which words the
// master sent, which FIFO words should appear on miso and how many pops
// a transaction of a given length should cost.
// -----------------------------------------------------------------------------
module tb_api_slave;

   localparam int SYNC_STAGES = 2;
   localparam int RESP_LEN    = 4;
   localparam int HALF_SCK    = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  reg_word_num;
   logic        load;
   logic        sck;
   logic        mosi;
   logic        miso;
   logic        rx_vld;
   logic [31:0] rx_dat;
   logic [7:0]  rx_idx;
   logic        rx_last;
   logic        rx_abort;
   logic        resp_empty;
   logic        resp_rd_en;
   logic [31:0] resp_dout;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mosi_words [0:7];
   logic [31:0] miso_cap   [0:7];
   logic [31:0] fifo_mem   [0:7];
   int          fifo_n     = 0;
   int          fifo_base  = 0;
   int          fifo_idx;
   int          pops_total  = 0;
   int          rx_total    = 0;
   int          abort_total = 0;
   logic [31:0] ev_dat  [0:255];
   logic [7:0]  ev_idx  [0:255];
   logic        ev_last [0:255];

   api_slave #(
      .SYNC_STAGES(SYNC_STAGES),
      .RESP_LEN   (RESP_LEN),
      .IDLE_MISO  (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .reg_word_num(reg_word_num),
      .load        (load),
      .sck         (sck),
      .mosi        (mosi),
      .miso        (miso),
      .rx_vld      (rx_vld),
      .rx_dat      (rx_dat),
      .rx_idx      (rx_idx),
      .rx_last     (rx_last),
      .rx_abort    (rx_abort),
      .resp_empty  (resp_empty),
      .resp_rd_en  (resp_rd_en),
      .resp_dout   (resp_dout),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // First-word-fall-through FIFO model: head is selected by pops so far.
   always_comb begin
      fifo_idx   = pops_total - fifo_base;
      resp_empty = (fifo_idx >= fifo_n);
      resp_dout  = fifo_mem[fifo_idx[2:0]];
   end

   always @(posedge clk) begin
      if (resp_rd_en) begin
         pops_total <= pops_total + 1;
      end
   end

   // Receive monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (rx_vld) begin
         ev_dat[rx_total[7:0]]  <= rx_dat;
         ev_idx[rx_total[7:0]]  <= rx_idx;
         ev_last[rx_total[7:0]] <= rx_last;
         rx_total <= rx_total + 1;
      end
      if (rx_abort) begin
         abort_total <= abort_total + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   // Expected miso word for word w when the FIFO starts with nf entries.
   function automatic logic [31:0] expMiso(input int w, input int nf);
      if ((w < RESP_LEN) && (w < nf)) begin
         return fifo_mem[w];
      end
      return 32'hFFFF_FFFF;
   endfunction

   function automatic int minOf3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b < m) m = b;
      if (c < m) m = c;
      return m;
   endfunction

   // Master: select, then issue the given number of mode-0 sck pulses.
   // mosi changes with sck falling; miso is captured as sck rises.
   task automatic applyStimulus(input int pulses);
      @(negedge clk);
      load = 1'b0;
      repeat (6) @(negedge clk);
      for (int p = 0; p < pulses; p++) begin
         int w;
         int b;
         w = (p / 32) & 7;
         b = 31 - (p % 32);
         mosi = mosi_words[w][b];
         repeat (HALF_SCK) @(negedge clk);
         sck = 1'b1;
         miso_cap[w][b] = miso;
         repeat (HALF_SCK) @(negedge clk);
         sck = 1'b0;
      end
      repeat (6) @(negedge clk);
   endtask

   // Full transaction of nw words with nf FIFO entries, plus optional
   // surplus sck pulses while the slave sits in HOLD.
   task automatic runTxn(input int nw, input int nf, input int extra, input logic fixed);
      int rx_base;
      int pop_base;
      int abort_base;
      if (!fixed) begin
         for (int i = 0; i < 8; i++) begin
            mosi_words[i] = $urandom;
            fifo_mem[i]   = $urandom;
         end
      end
      reg_word_num = 8'(nw);
      fifo_n       = nf;
      fifo_base    = pops_total;
      rx_base      = rx_total;
      pop_base     = pops_total;
      abort_base   = abort_total;
      applyStimulus(32 * nw + extra);
      checkOutput("hold_busy", 32'(busy), 32'd1);
      checkOutput("hold_miso", 32'(miso), 32'd1);
      load = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("rx_count", 32'(rx_total - rx_base), 32'(nw));
      for (int w = 0; w < nw; w++) begin
         checkOutput("rx_dat", ev_dat[(rx_base + w) & 255], mosi_words[w]);
         checkOutput("rx_idx", 32'(ev_idx[(rx_base + w) & 255]), 32'(w));
         checkOutput("rx_last", 32'(ev_last[(rx_base + w) & 255]), 32'(w == nw - 1));
         checkOutput("miso_word", miso_cap[w], expMiso(w, nf));
      end
      checkOutput("pops", 32'(pops_total - pop_base), 32'(minOf3(nw, nf, RESP_LEN)));
      checkOutput("no_abort", 32'(abort_total - abort_base), 32'd0);
   endtask

   task automatic checkResetOutputs();
      checkOutput("rst_rx_vld", 32'(rx_vld), 32'd0);
      checkOutput("rst_rx_dat", rx_dat, 32'd0);
      checkOutput("rst_rx_idx", 32'(rx_idx), 32'd0);
      checkOutput("rst_rx_last", 32'(rx_last), 32'd0);
      checkOutput("rst_rx_abort", 32'(rx_abort), 32'd0);
      checkOutput("rst_rd_en", 32'(resp_rd_en), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_miso", 32'(miso), 32'd1);
   endtask

   initial begin
      int rx_base;
      int pop_base;
      int abort_base;
      rst          = 1'b1;
      load         = 1'b1;
      sck          = 1'b0;
      mosi         = 1'b0;
      reg_word_num = 8'd0;
      for (int i = 0; i < 8; i++) begin
         mosi_words[i] = '0;
         miso_cap[i]   = '0;
         fifo_mem[i]   = '0;
      end
      repeat (3) @(negedge clk);
      checkResetOutputs();
      rst = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] two-word transaction with fixed data");
      mosi_words[0] = 32'hDEAD_BEEF;
      mosi_words[1] = 32'h1234_5678;
      fifo_mem[0]   = 32'hA5A5_0001;
      fifo_mem[1]   = 32'h5A5A_0002;
      runTxn(2, 2, 0, 1'b1);

      $display("[TB] six words, four responses");
      runTxn(6, 4, 0, 1'b0);

      $display("[TB] single word, empty FIFO");
      runTxn(1, 0, 0, 1'b0);

      $display("[TB] surplus sck pulses in HOLD");
      runTxn(2, 1, 8, 1'b0);

      $display("[TB] randomized transactions");
      for (int t = 0; t < 4; t++) begin
         runTxn(int'($urandom_range(1, 5)), int'($urandom_range(0, 5)), 0, 1'b0);
      end

      $display("[TB] abort after 17 bits of word 0");
      for (int i = 0; i < 8; i++) begin
         mosi_words[i] = $urandom;
         fifo_mem[i]   = $urandom;
      end
      reg_word_num = 8'd2;
      fifo_n       = 2;
      fifo_base    = pops_total;
      rx_base      = rx_total;
      pop_base     = pops_total;
      abort_base   = abort_total;
      applyStimulus(17);
      checkOutput("abort_busy_before", 32'(busy), 32'd1);
      load = 1'b1;
      repeat (SYNC_STAGES + 2) @(negedge clk);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_miso", 32'(miso), 32'd1);
      checkOutput("abort_pulse", 32'(abort_total - abort_base), 32'd1);
      checkOutput("abort_no_rx", 32'(rx_total - rx_base), 32'd0);
      checkOutput("abort_pops", 32'(pops_total - pop_base), 32'd1);
      repeat (4) @(negedge clk);

      $display("[TB] reset in the middle of word 2");
      reg_word_num = 8'd3;
      fifo_n       = 0;
      fifo_base    = pops_total;
      applyStimulus(72);
      rx_base    = rx_total;
      abort_base = abort_total;
      rst  = 1'b1;
      load = 1'b1;
      sck  = 1'b0;
      @(negedge clk);
      checkResetOutputs();
      rst = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("rst_no_abort", 32'(abort_total - abort_base), 32'd0);
      checkOutput("rst_no_rx", 32'(rx_total - rx_base), 32'd0);
      runTxn(1, 1, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
